mem_port_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory between the pipeline MEM stage (CPU) and the UART loader.
- Serialises accesses and handles the configurable memory read latency.
- Drives cpu_stall into the hazard unit, so the pipeline freezes while its access is pending or blocked.
- CPU has default priority. A starvation counter guarantees UART progress.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/UART arbiter for the shared single-port data memory
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic          cpu_flush,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          uart_req,
  input  logic          uart_we,
  input  logic [AW-1:0] uart_addr,
  input  logic [15:0]   uart_wdata,
  output logic [15:0]   uart_rdata,
  output logic          uart_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  output logic          busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    lat_cnt;
  logic          owner_uart;
  logic          txn_we;
  logic          flushed;
  logic          uart_win;
  logic          flush_now;

  // UART wins when alone, or once the CPU has starved it for STARVE_MAX grants
  assign uart_win  = uart_req & (~cpu_req | (starve_cnt == SW'(STARVE_MAX)));
  // A flush only matters for a CPU read that is still in flight; it stays latched
  assign flush_now = flushed | (cpu_flush & ~owner_uart & ~txn_we);
  // The pipeline is frozen until its own completion pulse
  assign cpu_stall = cpu_req & ~cpu_done;

  // Arbitration FSM; memory strobe, data registers and done pulses are all registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= 2'd0;
      owner_uart <= 1'b0;
      txn_we     <= 1'b0;
      flushed    <= 1'b0;
      cpu_rdata  <= 16'h0;
      cpu_done   <= 1'b0;
      uart_rdata <= 16'h0;
      uart_done  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | uart_req) begin
            owner_uart <= uart_win;
            txn_we     <= uart_win ? uart_we : cpu_we;
            flushed    <= 1'b0;
            mem_en     <= 1'b1;
            mem_we     <= uart_win ? uart_we : cpu_we;
            mem_addr   <= uart_win ? uart_addr : cpu_addr;
            mem_wdata  <= uart_win ? uart_wdata : cpu_wdata;
            busy       <= 1'b1;
            if (uart_win) begin
              starve_cnt <= '0;
            end else if (uart_req && starve_cnt != SW'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= 16'h0;
          flushed   <= flush_now;
          if (txn_we) begin
            cpu_done  <= ~owner_uart;
            uart_done <= owner_uart;
            state     <= DONE;
          end else begin
            lat_cnt <= 2'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          flushed <= flush_now;
          if (lat_cnt == 2'd0) begin
            if (owner_uart) begin
              uart_rdata <= mem_rdata;
              uart_done  <= 1'b1;
            end else if (!flush_now) begin
              cpu_rdata <= mem_rdata;
              cpu_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DONE: begin
          cpu_done  <= 1'b0;
          uart_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int N      = 3;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_clr;

  always #5 clk = ~clk;

  logic        cpu_req [N];
  logic        cpu_we [N];
  logic [7:0]  cpu_addr [N];
  logic [15:0] cpu_wdata [N];
  logic        cpu_flush [N];
  logic [15:0] cpu_rdata [N];
  logic        cpu_done [N];
  logic        cpu_stall [N];
  logic        uart_req [N];
  logic        uart_we [N];
  logic [7:0]  uart_addr [N];
  logic [15:0] uart_wdata [N];
  logic [15:0] uart_rdata [N];
  logic        uart_done [N];
  logic        mem_en [N];
  logic        mem_we [N];
  logic [7:0]  mem_addr [N];
  logic [15:0] mem_wdata [N];
  logic [15:0] mem_rdata [N];
  logic        busy [N];

  logic [15:0] env_mem [N][256];
  logic [15:0] pipe [N][4];

  // Memory environment: writes land on the strobe, read data emerges RD_LAT cycles later
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_clr) begin
        for (int a = 0; a < 256; a++) env_mem[i][a] <= 16'h0;
      end else if (mem_en[i] && mem_we[i]) begin
        env_mem[i][mem_addr[i]] <= mem_wdata[i];
      end
      pipe[i][0] <= (mem_en[i] && !mem_we[i]) ? env_mem[i][mem_addr[i]] : 16'($urandom);
      for (int j = 1; j < 4; j++) pipe[i][j] <= pipe[i][j-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mem_port_arbiter #(.AW(8), .RD_LAT(L), .STARVE_MAX(STARVE)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_flush  (cpu_flush[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .cpu_done   (cpu_done[g]),
      .cpu_stall  (cpu_stall[g]),
      .uart_req   (uart_req[g]),
      .uart_we    (uart_we[g]),
      .uart_addr  (uart_addr[g]),
      .uart_wdata (uart_wdata[g]),
      .uart_rdata (uart_rdata[g]),
      .uart_done  (uart_done[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );
    assign mem_rdata[g] = pipe[g][L-1];
  end

  int          cur, k, idle_from, starve, n_checks, n_pass;
  bit          t_valid, t_uart, t_we, t_flushed;
  logic [7:0]  t_addr;
  logic [15:0] t_wdata, t_exp;
  int          t_issue, t_done;
  logic [15:0] ref_mem [256];
  logic [15:0] ref_crd, ref_urd;
  bit          s_req [2];
  bit          s_we [2];
  bit          s_granted [2];
  logic [7:0]  s_addr [2];
  logic [15:0] s_wdata [2];
  int          s_done [2];
  int          p [2];
  int          force_we, flush_mode;
  bit          flush_v;
  bit          log_on;
  int          log_n;
  logic [9:0]  obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst=%0d cycle=%0d got=%h expected=%h", tag, cur, k, got, exp);
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] outs_vec();
    return {2'b00, mem_en[cur], mem_we[cur], mem_addr[cur], mem_wdata[cur],
            busy[cur], cpu_done[cur], uart_done[cur], cpu_stall[cur]};
  endfunction

  task automatic apply();
    cpu_req[cur]    = s_req[0];
    cpu_we[cur]     = s_we[0];
    cpu_addr[cur]   = s_addr[0];
    cpu_wdata[cur]  = s_wdata[0];
    uart_req[cur]   = s_req[1];
    uart_we[cur]    = s_we[1];
    uart_addr[cur]  = s_addr[1];
    uart_wdata[cur] = s_wdata[1];
    cpu_flush[cur]  = flush_v;
  endtask

  task automatic new_fields(input int s);
    if (force_we < 0) s_we[s] = ($urandom_range(1) == 1);
    else s_we[s] = (force_we != 0);
    s_addr[s]  = {3'b010, 5'($urandom_range(31))};
    s_wdata[s] = 16'($urandom);
  endtask

  task automatic drive_sources();
    for (int s = 0; s < 2; s++) begin
      if (s_req[s] && s_granted[s] && k > s_done[s]) begin
        s_granted[s] = 0;
        if (int'($urandom_range(99)) < p[s]) new_fields(s);
        else s_req[s] = 0;
      end else if (!s_req[s] && int'($urandom_range(99)) < p[s]) begin
        s_req[s] = 1;
        new_fields(s);
      end
    end
    case (flush_mode)
      1:       flush_v = t_valid && !t_uart && !t_we && (k == t_issue + 1);
      2:       flush_v = ($urandom_range(4) == 0);
      default: flush_v = 0;
    endcase
  endtask

  task automatic arbitrate();
    int w;
    w = (s_req[1] && (!s_req[0] || starve == STARVE)) ? 1 : 0;
    if (w == 1) starve = 0;
    else if (s_req[1] && starve < STARVE) starve++;
    t_valid   = 1;
    t_uart    = (w == 1);
    t_we      = s_we[w];
    t_addr    = s_addr[w];
    t_wdata   = s_wdata[w];
    t_flushed = 0;
    t_issue   = k + 1;
    t_done    = t_we ? k + 2 : k + 2 + lat_of(cur);
    idle_from = t_done + 1;
    t_exp     = ref_mem[t_addr];
    if (t_we) ref_mem[t_addr] = t_wdata;
    s_granted[w] = 1;
    s_done[w]    = t_done;
  endtask

  task automatic cycle();
    bit e_en, e_cd, e_ud, e_busy;
    @(negedge clk);
    drive_sources();
    apply();
    #1;
    if (t_valid && k == t_done && !t_we) begin
      if (t_uart) ref_urd = t_exp;
      else if (!t_flushed) ref_crd = t_exp;
    end
    e_en   = t_valid && (k == t_issue);
    e_busy = t_valid && (k >= t_issue) && (k <= t_done);
    e_cd   = t_valid && (k == t_done) && !t_uart && !t_flushed;
    e_ud   = t_valid && (k == t_done) && t_uart;
    check("mem_en", 32'(mem_en[cur]), 32'(e_en));
    if (e_en) begin
      check("mem_we", 32'(mem_we[cur]), 32'(t_we));
      check("mem_addr", 32'(mem_addr[cur]), 32'(t_addr));
      if (t_we) check("mem_wdata", 32'(mem_wdata[cur]), 32'(t_wdata));
    end
    check("busy", 32'(busy[cur]), 32'(e_busy));
    check("cpu_done", 32'(cpu_done[cur]), 32'(e_cd));
    check("uart_done", 32'(uart_done[cur]), 32'(e_ud));
    check("cpu_stall", 32'(cpu_stall[cur]), 32'(s_req[0] && !e_cd));
    check("cpu_rdata", 32'(cpu_rdata[cur]), 32'(ref_crd));
    check("uart_rdata", 32'(uart_rdata[cur]), 32'(ref_urd));
    if (log_on && log_n < 10 && (cpu_done[cur] || uart_done[cur])) begin
      obs = {obs[8:0], uart_done[cur]};
      log_n++;
    end
    if (t_valid && !t_uart && !t_we && k >= t_issue && k < t_done && flush_v) t_flushed = 1;
    if (t_valid && k == t_done) t_valid = 0;
    if (k >= idle_from && (s_req[0] || s_req[1])) arbitrate();
    k++;
  endtask

  task automatic drain();
    int g = 0;
    p[0] = 0;
    p[1] = 0;
    while ((t_valid || s_req[0] || s_req[1]) && g < 200) begin
      cycle();
      g++;
    end
    if (g >= 200) check("drain_timeout", 32'(g), 32'(0));
    cycle();
  endtask

  task automatic one_shot(input int s, input bit we, input logic [7:0] a, input logic [15:0] d);
    s_req[s]     = 1;
    s_we[s]      = we;
    s_addr[s]    = a;
    s_wdata[s]   = d;
    s_granted[s] = 0;
    drain();
  endtask

  task automatic model_reset();
    t_valid   = 0;
    idle_from = k;
    starve    = 0;
    ref_crd   = 16'h0;
    ref_urd   = 16'h0;
    flush_v   = 0;
    for (int s = 0; s < 2; s++) begin
      s_req[s]     = 0;
      s_granted[s] = 0;
    end
  endtask

  task automatic start_inst(input int i);
    cur        = i;
    reset_n    = 0;
    mem_clr    = 1;
    force_we   = -1;
    flush_mode = 0;
    p[0]       = 0;
    p[1]       = 0;
    model_reset();
    for (int a = 0; a < 256; a++) ref_mem[a] = 16'h0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs_vec(), 32'h0);
    check("reset_rdata", {cpu_rdata[cur], uart_rdata[cur]}, 32'h0);
    @(negedge clk);
    reset_n = 1;
    mem_clr = 0;
  endtask

  task automatic reset_mid_wait();
    int g = 0;
    s_req[1]     = 1;
    s_we[1]      = 0;
    s_addr[1]    = 8'h10;
    s_wdata[1]   = 16'h0;
    s_granted[1] = 0;
    do begin
      cycle();
      g++;
    end while (!(t_valid && t_uart && (k - 1) == t_issue + 1) && g < 20);
    if (g >= 20) check("wait_reached", 32'(g), 32'(0));
    #1;
    reset_n  = 0;
    s_req[0] = 0;
    s_req[1] = 0;
    flush_v  = 0;
    apply();
    #1;
    check("async_rst_outs", outs_vec(), 32'h0);
    check("async_rst_rdata", {cpu_rdata[cur], uart_rdata[cur]}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_outs", outs_vec(), 32'h0);
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    k        = 0;
    cur      = 0;
    reset_n  = 0;
    mem_clr  = 1;
    log_on   = 0;
    log_n    = 0;
    obs      = '0;
    flush_v  = 0;
    for (int i = 0; i < N; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 8'h0; cpu_wdata[i] = 16'h0; cpu_flush[i] = 0;
      uart_req[i] = 0; uart_we[i] = 0; uart_addr[i] = 8'h0; uart_wdata[i] = 16'h0;
    end
    for (int s = 0; s < 2; s++) begin
      s_we[s] = 0; s_addr[s] = 8'h0; s_wdata[s] = 16'h0; s_done[s] = 0;
    end

    for (int ord = 0; ord < N; ord++) begin
      start_inst((ord + 1) % N);

      one_shot(1, 1, 8'h10, 16'hBEEF);
      one_shot(0, 0, 8'h10, 16'h0000);
      check("cpu_rd_beef", 32'(cpu_rdata[cur]), 32'h0000BEEF);

      one_shot(1, 1, 8'h20, 16'h1234);
      check("mem_0x20", 32'(env_mem[cur][32]), 32'h00001234);

      one_shot(0, 0, 8'h20, 16'h0000);
      flush_mode = 1;
      one_shot(0, 0, 8'h10, 16'h0000);
      flush_mode = 0;
      check("flush_keeps_rdata", 32'(cpu_rdata[cur]), 32'h00001234);

      force_we = 1;
      log_on   = 1;
      log_n    = 0;
      obs      = '0;
      p[0]     = 100;
      p[1]     = 100;
      repeat (40) cycle();
      drain();
      log_on   = 0;
      force_we = -1;
      check("grant_count", 32'(log_n), 32'd10);
      check("grant_order", 32'(obs), 32'h00000021);

      force_we = 0;
      p[0]     = 100;
      repeat (30) cycle();
      drain();
      force_we = -1;

      flush_mode = 2;
      p[0]       = 60;
      p[1]       = 60;
      repeat (300) cycle();
      flush_mode = 0;
      drain();

      reset_mid_wait();
      cycle();
      one_shot(0, 0, 8'h10, 16'h0000);
      check("post_rst_cpu_rd", 32'(cpu_rdata[cur]), 32'h0000BEEF);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
